uart_rx_frame_parser: RTL

Receive-side consumer placed directly downstream of the UART_TOP receiver. It takes one byte per strobe from rx_data_out/rx_en and parses framed packets of the form HEADER, LEN, LEN payload bytes, CSUM. It buffers the payload until the checksum has been verified, then streams the payload out over a valid/ready interface. Bad frames are reported with a one-cycle error pulse and a cause code.

---
 rtl/uart_rx_frame_parser.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_parser.sv
// Framed-packet parser behind the UART receiver: HEADER, LEN, payload, CSUM.
// Payload is held until the checksum passes, then streamed out over valid/ready.
`timescale 1ns/1ps
module uart_rx_frame_parser #(
  parameter logic [7:0] HEADER      = 8'h55,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic [7:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int IW    = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]    MAX_LEN_B    = 8'(MAX_LEN);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]    ERR_LEN      = 2'd1;
  localparam logic [1:0]    ERR_CSUM     = 2'd2;
  localparam logic [1:0]    ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t        state_r;
  logic [7:0]    buf_r [DEPTH];
  logic [IW-1:0] wr_idx_r;
  logic [IW-1:0] rd_idx_r;
  logic [IW-1:0] len_r;
  logic [7:0]    csum_r;
  logic [TW-1:0] timer_r;
  logic          frame_ok_r;
  logic [7:0]    frame_len_r;
  logic          frame_err_r;
  logic [1:0]    err_code_r;
  logic          overrun_r;
  logic [IW-1:0] len_m1_s;
  logic          rd_is_last_s;

  assign len_m1_s     = len_r - IW'(1);
  assign rd_is_last_s = (rd_idx_r == len_m1_s);

  assign frame_ok  = frame_ok_r;
  assign frame_len = frame_len_r;
  assign frame_err = frame_err_r;
  assign err_code  = err_code_r;
  assign overrun   = overrun_r;

  // Stream side: gated so every output reads 0 outside DRAIN.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    if (state_r == ST_DRAIN) begin
      out_valid = 1'b1;
      out_data  = buf_r[rd_idx_r[AW-1:0]];
      out_last  = rd_is_last_s;
    end else begin
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
    end
  end

  // Payload storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_PAYLOAD && rx_valid) begin
      buf_r[wr_idx_r[AW-1:0]] <= rx_data;
    end
  end

  // Frame parser FSM with inter-byte timeout and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wr_idx_r    <= {IW{1'b0}};
      rd_idx_r    <= {IW{1'b0}};
      len_r       <= {IW{1'b0}};
      csum_r      <= 8'h00;
      timer_r     <= {TW{1'b0}};
      frame_ok_r  <= 1'b0;
      frame_len_r <= 8'h00;
      frame_err_r <= 1'b0;
      err_code_r  <= 2'd0;
      overrun_r   <= 1'b0;
    end else begin
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          timer_r <= {TW{1'b0}};
          if (rx_valid && rx_data == HEADER) begin
            state_r <= ST_LEN;
          end
        end
        ST_LEN, ST_PAYLOAD, ST_CSUM: begin
          if (!rx_valid) begin
            // A byte on the expiry cycle takes the other branch, so it wins.
            if (timer_r == TIMEOUT_LAST) begin
              frame_err_r <= 1'b1;
              err_code_r  <= ERR_TIMEOUT;
              timer_r     <= {TW{1'b0}};
              state_r     <= ST_IDLE;
            end else begin
              timer_r <= timer_r + TW'(1);
            end
          end else begin
            timer_r <= {TW{1'b0}};
            case (state_r)
              ST_LEN: begin
                if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                  frame_err_r <= 1'b1;
                  err_code_r  <= ERR_LEN;
                  state_r     <= ST_IDLE;
                end else begin
                  len_r    <= rx_data[IW-1:0];
                  csum_r   <= rx_data;
                  wr_idx_r <= {IW{1'b0}};
                  state_r  <= ST_PAYLOAD;
                end
              end
              ST_PAYLOAD: begin
                csum_r   <= csum_add(csum_r, rx_data);
                wr_idx_r <= wr_idx_r + IW'(1);
                if (wr_idx_r == len_m1_s) begin
                  state_r <= ST_CSUM;
                end
              end
              ST_CSUM: begin
                if (rx_data == csum_r) begin
                  frame_ok_r  <= 1'b1;
                  frame_len_r <= 8'(len_r);
                  rd_idx_r    <= {IW{1'b0}};
                  state_r     <= ST_DRAIN;
                end else begin
                  frame_err_r <= 1'b1;
                  err_code_r  <= ERR_CSUM;
                  state_r     <= ST_IDLE;
                end
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_DRAIN: begin
          timer_r <= {TW{1'b0}};
          if (out_ready) begin
            rd_idx_r <= rd_idx_r + IW'(1);
          end
          // The final beat behaves as IDLE for a HEADER byte arriving alongside it.
          if (out_ready && rd_is_last_s) begin
            if (rx_valid && rx_data == HEADER) begin
              state_r <= ST_LEN;
            end else begin
              state_r <= ST_IDLE;
            end
            overrun_r <= rx_valid && (rx_data != HEADER);
          end else begin
            overrun_r <= rx_valid;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
